// File: rtl/jtag_reg_access_if.sv
// Debug-side request/response channel of the register-access sequencer.
// The debug module drives the master modport; the sequencer uses the slave modport.
interface jtag_reg_access_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/jtag_reg_access.sv
// Sequences debug register reads/writes onto the regfile JTAG port, retrying
// accesses that collide with execute-stage writes, with a bounded retry count.
module jtag_reg_access #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned RETRY_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  jtag_reg_access_if.slave  bus,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  output logic              jtag_we_o,
  output logic [ADDR_W-1:0] jtag_addr_o,
  output logic [XLEN-1:0]   jtag_data_o,
  input  logic [XLEN-1:0]   jtag_data_i
);

  localparam int unsigned CNT_W = $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              jtag_we_q;
  logic [ADDR_W-1:0] jtag_addr_q;
  logic [XLEN-1:0]   jtag_data_q;

  logic wr_coll_c;
  logic rd_coll_c;
  logic retry_left_c;

  // Any execute write to a real register wins the regfile port and drops ours;
  // a read only goes stale when execute is writing the same register.
  assign wr_coll_c    = ex_we_i && (ex_waddr_i != '0);
  assign rd_coll_c    = ex_we_i && (ex_waddr_i == jtag_addr_q) && (jtag_addr_q != '0);
  assign retry_left_c = (cnt_q != CNT_W'(RETRY_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      jtag_we_q    <= 1'b0;
      jtag_addr_q  <= '0;
      jtag_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            jtag_addr_q <= bus.req_addr;
            jtag_data_q <= bus.req_wdata;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (bus.req_we && (bus.req_addr == '0)) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              resp_err_q   <= 1'b0;
            end else if (bus.req_we) begin
              state_q   <= WR;
              jtag_we_q <= 1'b1;
            end else begin
              state_q <= RD;
            end
          end
        end

        WR: begin
          if (!wr_coll_c) begin
            state_q      <= RESP;
            jtag_we_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= jtag_data_q;
            resp_err_q   <= 1'b0;
          end else if (retry_left_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q      <= RESP;
            jtag_we_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
          end
        end

        RD: begin
          if (!rd_coll_c) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= jtag_data_i;
            resp_err_q   <= 1'b0;
          end else if (retry_left_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          jtag_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign jtag_we_o      = jtag_we_q;
  assign jtag_addr_o    = jtag_addr_q;
  assign jtag_data_o    = jtag_data_q;

endmodule

// File: doc/jtag_reg_access.md
Name: jtag_reg_access

Overview:
- Sequencer between the debug module's register-access request channel and the JTAG port of the general-purpose register file.
- Turns one valid/ready request (read or write of x0..x31) into a correctly timed access on the regfile JTAG port.
- The regfile gives the execute-stage write priority and does not forward execute data to the JTAG read port. This block therefore retries any access that collides with an execute-stage write.
- Returns one response per request, with an error flag when a bounded retry count is exhausted.

Parameters:
- XLEN, 32, register data width
- ADDR_W, 5, register address width
- RETRY_MAX, 15, collision retries allowed before error; minimum 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  debug request valid
- req_ready_o  out  1  block can accept request
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  ADDR_W  target register
- req_wdata_i  in  XLEN  write data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  debug side accepts response
- resp_data_o  out  XLEN  read data, or written data echoed back
- resp_err_o  out  1  retry limit exhausted, access not performed
- ex_we_i  in  1  execute-stage regfile write enable (same signal the regfile sees)
- ex_waddr_i  in  ADDR_W  execute-stage write address
- jtag_we_o  out  1  regfile JTAG write enable
- jtag_addr_o  out  ADDR_W  regfile JTAG address
- jtag_data_o  out  XLEN  regfile JTAG write data
- jtag_data_i  in  XLEN  regfile JTAG read data (combinational from regfile)

Behaviour:
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_data_o=0, jtag_we_o=0, jtag_addr_o=0, jtag_data_o=0, retry counter=0.
- Reset mid-operation drops any pending request with no response. All outputs take their reset values at the sampling edge.
- States: IDLE, WR, RD, RESP.
- Handshake: accept when req_valid_i && req_ready_o. req_ready_o=1 only in IDLE. resp_valid_o=1 only in RESP.
- IDLE, on accept: latch addr and wdata into jtag_addr_o and jtag_data_o, clear retry counter, then:
  - write to addr 0 -> RESP, resp_data=0, err=0, no jtag_we pulse;
  - other write -> WR;
  - read -> RD.
- WR: jtag_we_o=1 (state-decoded) for the whole cycle.
  - Collision = ex_we_i && ex_waddr_i!=0 (the regfile drops the JTAG write).
  - No collision: write commits at this edge; -> RESP, resp_data=wdata, err=0.
  - Collision with counter<RETRY_MAX: counter+1, stay in WR.
  - Collision with counter==RETRY_MAX: -> RESP, err=1, resp_data=0, jtag_we_o drops.
- RD: jtag_we_o=0.
  - Collision = ex_we_i && ex_waddr_i==jtag_addr_o && jtag_addr_o!=0 (read value would be stale).
  - No collision: capture jtag_data_i into resp_data_o; -> RESP, err=0. Address 0 returns the regfile's 0.
  - Collision: same retry/timeout rule as WR.
- RESP: hold resp_data_o and resp_err_o stable. When resp_ready_i=1 -> IDLE and resp_valid_o=0 next cycle. A new request is accepted no earlier than the cycle after the response handshake.
- Uncontended latency: handshake in cycle k; WR/RD in cycle k+1; resp_valid_o high from cycle k+2.
- Each retry adds exactly one cycle. Worst case: the access is attempted RETRY_MAX+1 times, then the error response follows.
- jtag_addr_o and jtag_data_o change only on accept or reset. They hold between requests.
- Retry counter width is clog2(RETRY_MAX+1). It never wraps.

Test Plan:
- Write x5=0xDEADBEEF, ex idle -> jtag_we_o high exactly in cycle k+1. resp_valid_o in k+2 with data 0xDEADBEEF, err=0. Regfile x5 reads 0xDEADBEEF.
- Write x7=0x12345678 with ex_we_i=1, ex_waddr_i=3 for 3 cycles -> jtag_we_o high 4 cycles, response at k+5, err=0, x7 correct.
- ex_we_i=1, ex_waddr_i=9 held for 20 cycles; write x4 -> 16 attempts, resp_err_o=1, resp_data_o=0, x4 unchanged.
- Read x10 (holding 0x11) while ex writes 0x22 to x10 for 1 cycle -> one retry, resp_data_o=0x22. A read of x10 while ex writes x11 -> no retry, 0x11 → value.
- Write x0=0xFFFFFFFF -> no jtag_we pulse, resp at k+1 with data 0, err=0. Hold resp_ready_i=0 for 5 cycles -> response stable, req_ready_o=0 throughout.
- Assert rst for 1 cycle while in WR with collision -> at the edge all outputs reset, no response emitted, the next request completes normally.
